// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one left-rotating barrel shifter among NREQ requesters
// Optional burst lock enabled by defining SHIFT_ARB_LOCK_EN.
module shift_arbiter #(
    parameter int CTRL  = 5,
    parameter int WIDTH = 2**CTRL,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ*CTRL-1:0]  req_shift,
    input  logic [NREQ-1:0]       req_lock,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [IDW-1:0]        out_id
);

    logic                 acc;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       grant;
    logic                 grant_found;
    logic                 hs;
    logic [IDW-1:0]       ptr_next;
    logic [IDW:0]         cand;
    logic [WIDTH-1:0]     sel_data;
    logic [CTRL-1:0]      sel_shift;
    logic [2*WIDTH-1:0]   doubled;
    logic [WIDTH-1:0]     rotated;

`ifdef SHIFT_ARB_LOCK_EN
    logic                 locked;
    logic [IDW-1:0]       lock_id;
`else
    logic                 unused_lock;
    assign unused_lock = ^req_lock;
`endif

    assign acc = !out_valid || out_ready;

    // Descending scan so the candidate closest to ptr is the last one written.
    always_comb begin
        grant       = ptr;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (req_valid[cand[IDW-1:0]]) begin
                grant       = cand[IDW-1:0];
                grant_found = 1'b1;
            end
        end
`ifdef SHIFT_ARB_LOCK_EN
        if (locked) begin
            grant       = lock_id;
            grant_found = req_valid[lock_id];
        end
`endif
    end

    assign hs = !rst && acc && grant_found;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = hs && (grant == IDW'(i));
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_shift = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_data  = req_data[i*WIDTH +: WIDTH];
                sel_shift = req_shift[i*CTRL +: CTRL];
            end
        end
    end

    // Bits shifted out of the upper copy are refilled from the lower copy.
    assign doubled  = {sel_data, sel_data} << sel_shift;
    assign rotated  = doubled[2*WIDTH-1:WIDTH];
    assign ptr_next = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= '0;
        end else if (hs) begin
            out_valid <= 1'b1;
            out_data  <= rotated;
            out_id    <= grant;
            ptr       <= ptr_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SHIFT_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            locked  <= 1'b0;
            lock_id <= '0;
        end else if (hs) begin
            locked  <= req_lock[grant];
            if (req_lock[grant]) begin
                lock_id <= grant;
            end
        end
    end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - self-checking bench for shift_arbiter
module tb_shift_arbiter;
    localparam int CTRL  = 5;
    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ*CTRL-1:0]  req_shift;
    logic [NREQ-1:0]       req_lock;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_id;

    always #5 clk = ~clk;

    shift_arbiter #(.CTRL(CTRL), .WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_shift(req_shift), .req_lock(req_lock),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id)
    );

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
    } sb_t;

    typedef struct {
        logic [NREQ-1:0] v;
        logic            ordy;
        logic [NREQ-1:0] rdy;
        logic            ov;
        logic [IDW-1:0]  id;
    } vec_t;

    sb_t              sb_q[$];
    vec_t             tbl[19];
    int               checks = 0;
    int               failures = 0;
    int               m_ptr;
    bit               m_valid;
    bit               m_locked;
    int               m_lock_id;
    logic [WIDTH-1:0] dat[NREQ];
    logic [CTRL-1:0]  sh[NREQ];
    logic [NREQ-1:0]  last_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rot_ref(input logic [WIDTH-1:0] d, input int s);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int j = 0; j < WIDTH; j++) r[(j + s) % WIDTH] = d[j];
        return r;
    endfunction

    // One clock: drive at negedge, check ready, predict, clock, check outputs.
    task automatic step(input logic [NREQ-1:0] v, input logic ordy, input logic [NREQ-1:0] lk);
        int              g;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] seen;
        sb_t             e;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*WIDTH +: WIDTH] = dat[i];
            req_shift[i*CTRL +: CTRL]  = sh[i];
        end
        req_valid = v;
        out_ready = ordy;
        req_lock  = lk;
        #1;
        g = -1;
        if (!m_valid || ordy) begin
            if (m_locked) begin
                if (v[m_lock_id]) g = m_lock_id;
            end else begin
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        last_rdy = req_ready;
        seen = req_valid & req_ready;
        if (g >= 0) sb_q.push_back({IDW'(g), rot_ref(dat[g], int'(sh[g]))});
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_valid = 1'b1;
            m_ptr   = (g + 1) % NREQ;
`ifdef SHIFT_ARB_LOCK_EN
            if (lk[g]) begin
                m_locked  = 1'b1;
                m_lock_id = g;
            end else begin
                m_locked = 1'b0;
            end
`endif
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        if (seen != '0) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=grant required=none");
            end else begin
                e = sb_q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_id", out_id, e.id);
            end
        end
        chk("out_valid", out_valid, m_valid);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '1;
        out_ready = 1'b1;
        req_lock  = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("rst_ready", req_ready, 0);
            chk("rst_valid", out_valid, 0);
        end
        @(negedge clk);
        rst       = 1'b0;
        m_ptr     = 0;
        m_valid   = 1'b0;
        m_locked  = 1'b0;
        m_lock_id = 0;
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_data  = '0;
        req_shift = '0;
        for (int i = 0; i < NREQ; i++) begin
            dat[i] = '0;
            sh[i]  = '0;
        end
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[10] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[13] = '{4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[14] = '{4'b1100, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[15] = '{4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[16] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[17] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        do_reset();

        for (int t = 0; t < 19; t++) begin
            logic [WIDTH-1:0] held;
            held = out_data;
            for (int i = 0; i < NREQ; i++) begin
                dat[i] = $urandom;
                sh[i]  = CTRL'($urandom_range(0, WIDTH - 1));
            end
            step(tbl[t].v, tbl[t].ordy, 4'b0000);
            chk($sformatf("tbl%0d_ready", t), last_rdy, tbl[t].rdy);
            chk($sformatf("tbl%0d_valid", t), out_valid, tbl[t].ov);
            if (tbl[t].ov) chk($sformatf("tbl%0d_id", t), out_id, tbl[t].id);
            if (tbl[t].ordy == 1'b0 && tbl[t].ov) chk($sformatf("tbl%0d_hold", t), out_data, held);
        end

        dat[1] = 32'h8000_0001;
        sh[1]  = 5'd1;
        step(4'b0010, 1'b1, 4'b0000);
        chk("rot_by1", out_data, 32'h0000_0003);
        chk("rot_by1_id", out_id, 1);
        sh[1] = 5'd0;
        step(4'b0010, 1'b1, 4'b0000);
        chk("rot_by0", out_data, 32'h8000_0001);
        sh[1] = 5'd31;
        step(4'b0010, 1'b1, 4'b0000);
        chk("rot_by31", out_data, 32'hC000_0000);

        step(4'b1111, 1'b0, 4'b0000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_id", out_id, 0);
        @(negedge clk);
        rst       = 1'b0;
        m_ptr     = 0;
        m_valid   = 1'b0;
        m_locked  = 1'b0;
        sb_q.delete();
        step(4'b1111, 1'b1, 4'b0000);
        chk("first_after_rst", last_rdy, 4'b0001);

        do_reset();
        for (int i = 0; i < NREQ; i++) dat[i] = $urandom;
`ifdef SHIFT_ARB_LOCK_EN
        step(4'b0011, 1'b1, 4'b0001);
        chk("lock_b0", out_id, 0);
        step(4'b0011, 1'b1, 4'b0001);
        chk("lock_b1", out_id, 0);
        step(4'b0010, 1'b1, 4'b0000);
        chk("lock_bubble", last_rdy, 4'b0000);
        step(4'b0011, 1'b1, 4'b0000);
        chk("lock_b2", out_id, 0);
        step(4'b0011, 1'b1, 4'b0000);
        chk("lock_after", out_id, 1);
`else
        step(4'b0011, 1'b1, 4'b0001);
        chk("nolock_b0", out_id, 0);
        step(4'b0011, 1'b1, 4'b0001);
        chk("nolock_b1", out_id, 1);
`endif
        step(4'b0000, 1'b1, 4'b0000);
        chk("sb_drain", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin arbiter that shares one rotating barrel shifter (left rotate, `CTRL`-bit amount) among `NREQ` requesters. Each requester issues a data word and a rotate amount with a valid/ready handshake. The block grants one request per cycle, rotates the word, and holds the result in a single output register tagged with the requester index. It sits between the lane-packing front ends and the shared rotator in the Proteus datapath.

## Interface
Parameters:
- `CTRL`, 5, rotate-amount width
- `WIDTH`, 2**CTRL, data width
- `NREQ`, 4, number of requesters (≥2)
- `IDW`, $clog2(NREQ), width of the requester tag

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero
- `req_data`  in  NREQ*WIDTH  flattened data; requester i at `[i*WIDTH +: WIDTH]`
- `req_shift`  in  NREQ*CTRL  flattened rotate amounts; requester i at `[i*CTRL +: CTRL]`
- `req_lock`  in  NREQ  burst lock; hold the grant after this beat (used only with `SHIFT_ARB_LOCK_EN`)
- `out_valid`  out  1  result register full
- `out_ready`  in  1  downstream accept
- `out_data`  out  WIDTH  rotated result
- `out_id`  out  IDW  index of the requester that produced `out_data`

## Operation
- Rotation: `out_data` = `req_data[i]` rotated left by `req_shift[i]`. Bit j moves to bit (j+shift) mod WIDTH. A shift of 0 passes the data through.
- Register state:
  - output register: `out_valid`, `out_data`, `out_id`
  - round-robin pointer `ptr` (IDW bits)
  - lock state: `locked`, `lock_id`
- Accept condition `acc` = `!out_valid || out_ready`.
- Grant selection:
  - Pick the first i with `req_valid[i]`, searching from `ptr` upward and wrapping modulo NREQ.
  - `req_ready[i]` = `acc && grant==i`. `req_ready` is combinational from `req_valid`, `out_valid` and `out_ready`.
- On a handshake (`req_valid[i] && req_ready[i]`):
  - load the output register with the rotated data and id i
  - set `ptr` to (i+1) mod NREQ
- If `out_valid && out_ready` and no new grant occurs, clear `out_valid`.
- If `acc` is 0, the output register holds and `req_ready` is all-zero.
- Requesters must hold `req_valid`, `req_data` and `req_shift` stable until accepted. The arbiter stores nothing for ungranted requesters.
- `ptr` changes only on a grant. Idle cycles do not rotate priority.
- Every requester that holds `req_valid` high is granted within NREQ accepted beats (no starvation).

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_id`=0
  - `ptr`=0, `locked`=0, `lock_id`=0
  - `req_ready`=0 while `rst` is high
- Reset mid-transaction discards the held result and any lock.
- Latency: a request accepted at edge k appears on `out_data`/`out_id` with `out_valid`=1 after edge k.
- Throughput: 1 result/cycle while `out_ready` is held high.
- A simultaneous drain and load in the same cycle keeps `out_valid`=1 with the new data, with no bubble.
- Backpressure: with `out_ready`=0 and `out_valid`=1, `out_data`/`out_id` stay stable and no grant is issued.
- `NREQ` not a power of 2: the pointer wraps from NREQ-1 to 0, and `out_id` never exceeds NREQ-1.

## Configuration
- `SHIFT_ARB_LOCK_EN` defined:
  - A beat accepted from requester i with `req_lock[i]`=1 sets `locked`=1 and `lock_id`=i.
  - While locked, only `lock_id` may be granted. If `req_valid[lock_id]` is 0, no grant is issued and the cycle is a bubble. `ptr` does not change.
  - A beat from `lock_id` with `req_lock`=0 clears `locked` and sets `ptr` to `lock_id`+1.
- `SHIFT_ARB_LOCK_EN` undefined: `req_lock` is ignored, the lock registers are absent, and every grant is plain round-robin.

## Test plan
- Reset with all valids high (WIDTH=32, NREQ=4) → `req_ready`=0 and `out_valid`=0 during reset. First grant after reset goes to id 0.
- Requester 1 sends data 0x80000001 with shift 1, `out_ready`=1 → next cycle `out_data`=0x00000003, `out_id`=1. Also check shift 0 → data unchanged, and shift 31 → 0x80000001 becomes 0xC0000000.
- All 4 requesters valid continuously, `out_ready`=1 → `out_id` sequence is 0,1,2,3,0,… with one result every cycle.
- `out_ready`=0 for 5 cycles with a result held → `out_data` is stable, `req_ready`=0 throughout. Raise `out_ready` → the held result drains and a new grant loads in the same cycle.
- Only requesters 2 and 3 valid, with `ptr`=3 after a grant to id 2 → next grant goes to id 3, then id 2.
- With `SHIFT_ARB_LOCK_EN`, requester 0 sends 3 beats with `req_lock`=1,1,0 while requester 1 is valid throughout → `out_id` sequence is 0,0,0,1. Dropping `req_valid[0]` mid-burst produces bubbles, not grants to id 1.
